pc_sequencer: RTL

Multicycle instruction-fetch controller that owns the program counter and sequences the next-PC calculator. It issues requests to instruction memory with a req/ack handshake and holds each returned instruction until the decode stage takes it. It accepts branch/jump redirects from execute and applies them at the next PC update with MIPS delay-slot semantics, so the in-flight or held instruction is never squashed.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_npc.sv | 26 ++
 rtl/pc_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: next-PC op codes, FSM states
// and the branch offset helper used by the next-PC calculator.
package pc_sequencer_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } fetch_state_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_npc.sv
// Next-PC calculator: sequential, PC-relative branch and region jump targets.
// Op code 2'b11 falls through to the sequential path.
module pc_sequencer_npc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] base,
    input  logic [1:0]  op,
    input  logic [25:0] imm,
    output logic [31:0] npc
);

    logic [31:0] seq_s;

    assign seq_s = base + 32'd4;

    // select the target for the requested op
    always_comb begin
        npc = seq_s;
        case (op)
            NPC_BRANCH: npc = seq_s + branch_offset(imm[15:0]);
            NPC_JUMP:   npc = {seq_s[31:28], imm, 2'b00};
            default:    npc = seq_s;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch controller: owns the PC, runs the imem req/ack handshake and
// applies branch/jump redirects at the next PC update with delay-slot semantics.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    output logic        redirect_ready,
    input  logic [1:0]  redirect_op,
    input  logic [25:0] redirect_imm,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic         imem_req_q, imem_req_d;
    logic         pending_q, pending_d;
    logic [1:0]   p_op_q, p_op_d;
    logic [25:0]  p_imm_q, p_imm_d;
    logic [31:0]  p_pc_q, p_pc_d;

    logic         accept_s;
    logic         handoff_s;
    logic [31:0]  npc_base_s;
    logic [1:0]   npc_op_s;
    logic [25:0]  npc_imm_s;
    logic [31:0]  npc_s;

    assign accept_s  = redirect_valid && !pending_q;
    assign handoff_s = (state_q == ST_HOLD) && !stall;

    // next-PC source: same-cycle redirect bypasses the pending register
    always_comb begin
        npc_base_s = pc_q;
        npc_op_s   = NPC_PLUS4;
        npc_imm_s  = 26'd0;
        if (accept_s) begin
            npc_base_s = redirect_pc;
            npc_op_s   = redirect_op;
            npc_imm_s  = redirect_imm;
        end else if (pending_q) begin
            npc_base_s = p_pc_q;
            npc_op_s   = p_op_q;
            npc_imm_s  = p_imm_q;
        end else begin
            npc_base_s = pc_q;
            npc_op_s   = NPC_PLUS4;
            npc_imm_s  = 26'd0;
        end
    end

    pc_sequencer_npc u_npc (
        .base (npc_base_s),
        .op   (npc_op_s),
        .imm  (npc_imm_s),
        .npc  (npc_s)
    );

    // fetch FSM, pending redirect and output register next-state
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        pending_d    = pending_q;
        p_op_d       = p_op_q;
        p_imm_d      = p_imm_q;
        p_pc_d       = p_pc_q;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    pc_d         = npc_s;
                    inst_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // a handoff always consumes the redirect, whether bypassed or pending
        if (handoff_s) begin
            pending_d = 1'b0;
        end else if (accept_s) begin
            pending_d = 1'b1;
            p_op_d    = redirect_op;
            p_imm_d   = redirect_imm;
            p_pc_d    = redirect_pc;
        end else begin
            pending_d = pending_q;
        end

        imem_req_d = (state_d == ST_FETCH);
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            pending_q    <= 1'b0;
            p_op_q       <= 2'b00;
            p_imm_q      <= 26'd0;
            p_pc_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            pending_q    <= pending_d;
            p_op_q       <= p_op_d;
            p_imm_q      <= p_imm_d;
            p_pc_q       <= p_pc_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign redirect_ready = !pending_q;

endmodule
